// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_queue
//  Description : Decoder-to-issue instruction queue. Accepts up to two
//                in-order instructions per cycle from the decoder and
//                delivers one per cycle to issue over valid/ready. Ready is
//                raised only when two slots are free so a dual push is never
//                split. A flush empties the queue in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_queue #(
    parameter int  DEPTH         = 8,
    parameter type decoded_instr = logic [31:0]
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    output logic                       ready_o,
    input  logic                       valid_i_1,
    input  decoded_instr               data_i_1,
    input  logic                       valid_i_2,
    input  decoded_instr               data_i_2,
    output logic                       valid_o,
    output decoded_instr               data_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Highest occupancy that still leaves two free slots.
    localparam logic [CW-1:0] c_ready_max = CW'(DEPTH - 2);

    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    decoded_instr   mem_q [DEPTH];

    logic           w_push1;
    logic           w_push2;
    logic           w_pop;
    logic [AW-1:0]  w_tail_plus1;

    // Ready depends only on registered occupancy, never on inputs.
    assign ready_o = (count_q <= c_ready_max);
    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[head_q];
    assign count_o = count_q;

    // The second push is only honoured together with the first, keeping order.
    assign w_push1      = valid_i_1 & ready_o;
    assign w_push2      = valid_i_2 & valid_i_1 & ready_o;
    assign w_pop        = valid_o & ready_i;
    assign w_tail_plus1 = tail_q + AW'(1);

    // Next-state pointers and occupancy; flush overrides every other request.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(w_pop);
            tail_d  = tail_q + AW'(w_push1) + AW'(w_push2);
            count_d = count_q + CW'(w_push1) + CW'(w_push2) - CW'(w_pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; the older instruction lands at tail, the younger at tail+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush) begin
            if (w_push1) begin
                mem_q[tail_q] <= data_i_1;
            end
            if (w_push2) begin
                mem_q[w_tail_plus1] <= data_i_2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_queue
//  Description : Directed self-checking bench for instr_queue (DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_queue;

    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int CW    = 3;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           flush     = 1'b0;
    logic           valid_i_1 = 1'b0;
    logic           valid_i_2 = 1'b0;
    logic           ready_i   = 1'b0;
    logic [W-1:0]   data_i_1  = '0;
    logic [W-1:0]   data_i_2  = '0;
    logic           ready_o;
    logic           valid_o;
    logic [W-1:0]   data_o;
    logic [CW-1:0]  count_o;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [W-1:0] A = 32'hA0A0_0001;
    localparam logic [W-1:0] B = 32'hB0B0_0002;
    localparam logic [W-1:0] C = 32'hC0C0_0003;
    localparam logic [W-1:0] D = 32'hD0D0_0004;
    localparam logic [W-1:0] E = 32'hE0E0_0005;
    localparam logic [W-1:0] X = 32'h5A5A_0006;
    localparam logic [W-1:0] Y = 32'h6B6B_0007;

    instr_queue #(
        .DEPTH         (DEPTH),
        .decoded_instr (logic [31:0])
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .ready_o   (ready_o),
        .valid_i_1 (valid_i_1),
        .data_i_1  (data_i_1),
        .valid_i_2 (valid_i_2),
        .data_i_2  (data_i_2),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .ready_i   (ready_i),
        .count_o   (count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_i_1 = 1'b0;
        valid_i_2 = 1'b0;
        ready_i   = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic push2(input logic [W-1:0] d1, input logic [W-1:0] d2);
        valid_i_1 = 1'b1; data_i_1 = d1;
        valid_i_2 = 1'b1; data_i_2 = d2;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count_o); end
        n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_o); end
    endtask

    task automatic test_dual_push();
        push2(A, B);
        ready_i = 1'b0;
        tick();
        n_vec++; if (count_o !== 3'd2) begin n_err++; $display("FAIL dual_count1: got %0d want 2", count_o); end
        n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL dual_valid1: got %b want 1", valid_o); end
        n_vec++; if (data_o !== A) begin n_err++; $display("FAIL dual_data1: got %h want %h", data_o, A); end
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL dual_ready1: got %b want 1", ready_o); end
        push2(C, D);
        tick();
        n_vec++; if (count_o !== 3'd4) begin n_err++; $display("FAIL dual_count2: got %0d want 4", count_o); end
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL dual_ready2: got %b want 0", ready_o); end
        valid_i_1 = 1'b1; data_i_1 = E;
        valid_i_2 = 1'b0;
        tick();
        n_vec++; if (count_o !== 3'd4) begin n_err++; $display("FAIL full_ignore_count: got %0d want 4", count_o); end
        n_vec++; if (data_o !== A) begin n_err++; $display("FAIL full_ignore_head: got %h want %h", data_o, A); end
        idle();
    endtask

    task automatic test_drain();
        logic [W-1:0] exp_seq [4];
        exp_seq[0] = A; exp_seq[1] = B; exp_seq[2] = C; exp_seq[3] = D;
        idle();
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b want 1", i, valid_o); end
            n_vec++; if (data_o !== exp_seq[i]) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_o, exp_seq[i]); end
            n_vec++; if (ready_o !== (i >= 2)) begin n_err++; $display("FAIL drain_ready[%0d]: got %b want %b", i, ready_o, (i >= 2)); end
            tick();
        end
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL drain_empty_valid: got %b want 0", valid_o); end
        n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL drain_empty_count: got %0d want 0", count_o); end
        idle();
    endtask

    task automatic test_wrap();
        logic [W-1:0]  q [$];
        logic          exp_ready;
        logic          do_pop;
        logic          do_push;
        logic [CW-1:0] exp_count;
        q.delete();
        for (int c = 0; c < 10; c++) begin
            exp_ready = ((DEPTH - q.size()) >= 2);
            exp_count = CW'(q.size());
            if (c % 2 == 0) begin
                push2(32'h100 + 32'(2 * c), 32'h101 + 32'(2 * c));
                ready_i = 1'b0;
            end else begin
                valid_i_1 = 1'b0;
                valid_i_2 = 1'b0;
                ready_i   = 1'b1;
            end
            n_vec++; if (count_o !== exp_count) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want %0d", c, count_o, exp_count); end
            n_vec++; if (ready_o !== exp_ready) begin n_err++; $display("FAIL wrap_ready[%0d]: got %b want %b", c, ready_o, exp_ready); end
            if (q.size() != 0) begin
                n_vec++; if (data_o !== q[0]) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", c, data_o, q[0]); end
            end
            do_pop  = ready_i && (q.size() != 0);
            do_push = valid_i_1 && exp_ready;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(data_i_1);
                q.push_back(data_i_2);
            end
            tick();
        end
        idle();
        ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (q.size() != 0) begin
                n_vec++; if (data_o !== q[0]) begin n_err++; $display("FAIL wrap_drain[%0d]: got %h want %h", k, data_o, q[0]); end
                void'(q.pop_front());
                tick();
            end
        end
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL wrap_empty: got %b want 0", valid_o); end
        idle();
    endtask

    task automatic test_simul_push_pop();
        idle();
        push2(A, B);
        tick();
        valid_i_1 = 1'b1; data_i_1 = C;
        valid_i_2 = 1'b0;
        ready_i   = 1'b1;
        tick();
        n_vec++; if (count_o !== 3'd2) begin n_err++; $display("FAIL simul_count: got %0d want 2", count_o); end
        n_vec++; if (data_o !== B) begin n_err++; $display("FAIL simul_data: got %h want %h", data_o, B); end
        idle();
        valid_i_1 = 1'b1; data_i_1 = D;
        tick();
        n_vec++; if (count_o !== 3'd3) begin n_err++; $display("FAIL prefill_count: got %0d want 3", count_o); end
        idle();
    endtask

    task automatic test_flush();
        // Queue holds three entries here; ready_o is low.
        flush = 1'b1;
        push2(X, Y);
        ready_i = 1'b1;
        tick();
        n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count_o); end
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", valid_o); end
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", ready_o); end
        idle();
        push2(A, B);
        tick();
        flush = 1'b1;
        push2(X, Y);
        ready_i = 1'b1;
        tick();
        idle();
        n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL flush_drops_push: got %0d want 0", count_o); end
        tick();
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_stays_empty: got %b want 0", valid_o); end
    endtask

    task automatic test_reset_mid();
        idle();
        push2(A, B);
        tick();
        valid_i_1 = 1'b1; data_i_1 = C;
        valid_i_2 = 1'b0;
        tick();
        idle();
        ready_i = 1'b1;
        tick();
        n_vec++; if (count_o !== 3'd2) begin n_err++; $display("FAIL middrain_count: got %0d want 2", count_o); end
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL async_rst_count: got %0d want 0", count_o); end
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %b want 0", valid_o); end
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL async_rst_ready: got %b want 1", ready_o); end
        n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL async_rst_data: got %h want 0", data_o); end
        #2;
        rst_n = 1'b1;
        idle();
        tick();
        n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL post_rst_count: got %0d want 0", count_o); end
    endtask

    initial begin
        test_reset();
        test_dual_push();
        test_drain();
        test_wrap();
        test_simul_push_pop();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
